// File: rtl/rsa_word_port.sv
// rtl/rsa_word_port.sv - word-serial operand receiver and result transmitter for the RSA datapath
//
// Purpose: collects NUM_WORDS stream words into five wide operand registers
// (m/e/n/r/t) and serializes a wide result back out, least significant word first.
// Optional feature macro: RSA_RX_ODD_CHECK_EN (flags an even modulus on load completion).
//
// Ports:
//   clk, reset                 clock; synchronous active-high reset
//   load_start, in_valid       begin operand capture; per-cycle word valid
//   m/e/n/r/t_word             incoming operand words
//   m/e/n/r/t_op               assembled W-bit operands
//   ops_valid                  all operands complete (level)
//   busy                       FSM not idle
//   res_start, res_in          capture wide result and begin transmission
//   res_word/res_valid/res_last outgoing result stream
//   err                        sticky even-modulus flag (0 unless RSA_RX_ODD_CHECK_EN)

module rsa_word_port #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_WORDS  = 64,
  localparam int W         = DATA_WIDTH * NUM_WORDS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] m_word,
  input  logic [DATA_WIDTH-1:0] e_word,
  input  logic [DATA_WIDTH-1:0] n_word,
  input  logic [DATA_WIDTH-1:0] r_word,
  input  logic [DATA_WIDTH-1:0] t_word,
  output logic [W-1:0]          m_op,
  output logic [W-1:0]          e_op,
  output logic [W-1:0]          n_op,
  output logic [W-1:0]          r_op,
  output logic [W-1:0]          t_op,
  output logic                  ops_valid,
  output logic                  busy,
  input  logic                  res_start,
  input  logic [W-1:0]          res_in,
  output logic [DATA_WIDTH-1:0] res_word,
  output logic                  res_valid,
  output logic                  res_last,
  output logic                  err
);

  localparam int IDX_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     shift;

  logic restart;     // (re)begin operand capture at word 0
  logic capture;     // latch res_in and begin transmission
  logic accept;      // write current words into operand slice idx
  logic done;        // the accepted word is the last one
  logic send_beat;   // one result word leaves this cycle
  logic n_odd;       // bit 0 of the modulus as it will stand after this write

  // On a single-word load slice 0 is being written right now, so look at the
  // incoming word; otherwise slice 0 was written earlier in this same load.
  assign n_odd = (idx == '0) ? n_word[0] : n_op[0];

  always_comb begin
    state_next = state;
    restart    = 1'b0;
    capture    = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    send_beat  = 1'b0;
    case (state)
      IDLE: begin
        // load_start wins over a simultaneous res_start
        if (load_start) begin
          state_next = LOAD;
          restart    = 1'b1;
        end else if (res_start) begin
          state_next = SEND;
          capture    = 1'b1;
        end
      end
      LOAD: begin
        // no word is taken in a load_start cycle; res_start is ignored here
        if (load_start) begin
          restart = 1'b1;
        end else if (in_valid) begin
          accept = 1'b1;
          if (idx == LAST_IDX) begin
            done       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      SEND: begin
        send_beat = 1'b1;
        if (idx == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      m_op      <= '0;
      e_op      <= '0;
      n_op      <= '0;
      r_op      <= '0;
      t_op      <= '0;
      shift     <= '0;
      ops_valid <= 1'b0;
    end else begin
      state <= state_next;
      if (restart) begin
        idx       <= '0;
        ops_valid <= 1'b0;
      end
      if (capture) begin
        shift <= res_in;
        idx   <= '0;
      end
      if (accept) begin
        m_op[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= m_word;
        e_op[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= e_word;
        n_op[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= n_word;
        r_op[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= r_word;
        t_op[int'(idx)*DATA_WIDTH +: DATA_WIDTH] <= t_word;
        idx <= done ? '0 : idx + 1'b1;
      end
      if (done) begin
`ifdef RSA_RX_ODD_CHECK_EN
        ops_valid <= n_odd;
`else
        ops_valid <= 1'b1;
`endif
      end
      // The captured result drains toward the low word, so the output tap is
      // always the bottom slice and later res_in changes cannot leak in.
      if (send_beat) begin
        shift <= shift >> DATA_WIDTH;
        idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end
    end
  end

`ifdef RSA_RX_ODD_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      err <= 1'b0;
    end else if (restart) begin
      err <= 1'b0;
    end else if (done && !n_odd) begin
      err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

  assign busy      = (state != IDLE);
  assign res_valid = (state == SEND);
  assign res_last  = res_valid && (idx == LAST_IDX);
  assign res_word  = res_valid ? shift[DATA_WIDTH-1:0] : '0;

endmodule

// File: tb/tb_rsa_word_port.sv
// tb/tb_rsa_word_port.sv - directed self-checking bench for rsa_word_port

module tb_rsa_word_port;

  localparam int DW = 64;
  localparam int NW = 64;
  localparam int W  = DW * NW;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_start;
  logic          in_valid;
  logic [DW-1:0] m_word, e_word, n_word, r_word, t_word;
  logic [W-1:0]  m_op, e_op, n_op, r_op, t_op;
  logic          ops_valid;
  logic          busy;
  logic          res_start;
  logic [W-1:0]  res_in;
  logic [DW-1:0] res_word;
  logic          res_valid;
  logic          res_last;
  logic          err;

  int checks = 0;
  int errors = 0;
  int res_seen = 0;
  int rise;

  logic [W-1:0] exp_m, exp_e, exp_n, exp_r, exp_t, res_pat;

  rsa_word_port #(.DATA_WIDTH(DW), .NUM_WORDS(NW)) dut (
    .clk(clk), .reset(reset),
    .load_start(load_start), .in_valid(in_valid),
    .m_word(m_word), .e_word(e_word), .n_word(n_word), .r_word(r_word), .t_word(t_word),
    .m_op(m_op), .e_op(e_op), .n_op(n_op), .r_op(r_op), .t_op(t_op),
    .ops_valid(ops_valid), .busy(busy),
    .res_start(res_start), .res_in(res_in),
    .res_word(res_word), .res_valid(res_valid), .res_last(res_last),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] fm(input logic [DW-1:0] b, input int k);
    return b + 64'(k);
  endfunction
  function automatic logic [DW-1:0] fe(input logic [DW-1:0] b, input int k);
    return b + 64'(k) + 64'd1;
  endfunction
  function automatic logic [DW-1:0] fn(input logic [DW-1:0] b, input int k, input bit even);
    if (even && k == 0) return 64'h2;
    return 64'h8000_0000_0000_0001 | ((b + 64'(k)) << 1);
  endfunction
  function automatic logic [DW-1:0] fr(input logic [DW-1:0] b, input int k);
    return ~(b + 64'(k));
  endfunction
  function automatic logic [DW-1:0] ft(input logic [DW-1:0] b, input int k);
    return ~(b + 64'(k)) ^ 64'hF0F0_F0F0_F0F0_F0F0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // compares the first differing slice so the report line stays short
  task automatic chk_wide(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    int bad = 0;
    for (int k = 0; k < NW; k++) begin
      if (obs[k*DW +: DW] !== expv[k*DW +: DW]) begin
        bad = k;
        break;
      end
    end
    checks++;
    assert (obs[bad*DW +: DW] === expv[bad*DW +: DW]) else begin
      errors++;
      $error("FAIL %s slice %0d: observed %0h expected %0h", tag, bad,
             obs[bad*DW +: DW], expv[bad*DW +: DW]);
    end
  endtask

  task automatic set_words(input logic [DW-1:0] b, input int k, input bit even);
    m_word = fm(b, k);
    e_word = fe(b, k);
    n_word = fn(b, k, even);
    r_word = fr(b, k);
    t_word = ft(b, k);
  endtask

  task automatic build_exp(input logic [DW-1:0] b, input bit even);
    for (int k = 0; k < NW; k++) begin
      exp_m[k*DW +: DW] = fm(b, k);
      exp_e[k*DW +: DW] = fe(b, k);
      exp_n[k*DW +: DW] = fn(b, k, even);
      exp_r[k*DW +: DW] = fr(b, k);
      exp_t[k*DW +: DW] = ft(b, k);
    end
  endtask

  task automatic chk_ops(input string tag);
    chk_wide({tag, "_m"}, m_op, exp_m);
    chk_wide({tag, "_e"}, e_op, exp_e);
    chk_wide({tag, "_n"}, n_op, exp_n);
    chk_wide({tag, "_r"}, r_op, exp_r);
    chk_wide({tag, "_t"}, t_op, exp_t);
  endtask

  // Full load; r_out = ticks from the load_start edge to the first cycle
  // with ops_valid high (-1 if it never rises within the window).
  task automatic do_load(input logic [DW-1:0] b, input int sa, input int sb,
                         input bit even, input bit with_res, output int r_out);
    int t = 0;
    r_out = -1;
    load_start = 1'b1;
    res_start  = with_res;
    in_valid   = 1'b1;
    m_word = 64'hDEAD_BEEF_DEAD_BEEF; e_word = m_word; n_word = m_word;
    r_word = m_word; t_word = m_word;
    tick; t++;
    load_start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      if (k == sa || k == sb) begin
        in_valid = 1'b0;
        for (int s = 0; s < 3; s++) begin
          tick; t++;
          if (r_out < 0 && ops_valid) r_out = t;
          if (res_valid) res_seen++;
        end
      end
      set_words(b, k, even);
      in_valid = 1'b1;
      tick; t++;
      if (r_out < 0 && ops_valid) r_out = t;
      if (res_valid) res_seen++;
    end
    in_valid  = 1'b0;
    res_start = 1'b0;
    for (int s = 0; s < 2; s++) begin
      tick; t++;
      if (r_out < 0 && ops_valid) r_out = t;
      if (res_valid) res_seen++;
    end
  endtask

  initial begin
    reset = 1'b1; load_start = 1'b0; in_valid = 1'b0; res_start = 1'b0; res_in = '0;
    m_word = '0; e_word = '0; n_word = '0; r_word = '0; t_word = '0;
    for (int k = 0; k < NW; k++) res_pat[k*DW +: DW] = 64'hA5A5_0000_0000_0000 + 64'(k);

    // reset state
    tick; tick;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ops_valid", 64'(ops_valid), 64'd0);
    chk("rst_res_valid", 64'(res_valid), 64'd0);
    chk("rst_res_last", 64'(res_last), 64'd0);
    chk("rst_res_word", res_word, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk_wide("rst_m_op", m_op, '0);
    reset = 1'b0;
    tick;

    // plain load
    do_load(64'd0, -1, -1, 1'b0, 1'b0, rise);
    chk("load_rise", 64'(rise), 64'd65);
    build_exp(64'd0, 1'b0);
    chk_ops("load");
    chk("load_busy", 64'(busy), 64'd0);
    chk("load_err", 64'(err), 64'd0);

    // stalls at beats 10 and 40
    do_load(64'd7, 10, 40, 1'b0, 1'b0, rise);
    chk("stall_rise", 64'(rise), 64'd71);
    build_exp(64'd7, 1'b0);
    chk_ops("stall");

    // send, with res_in changed mid-stream and an ignored load_start
    res_in = res_pat;
    res_start = 1'b1;
    tick;
    res_start = 1'b0;
    for (int k = 0; k < NW; k++) begin
      chk($sformatf("send_valid_%0d", k), 64'(res_valid), 64'd1);
      chk($sformatf("send_word_%0d", k), res_word, res_pat[k*DW +: DW]);
      chk($sformatf("send_last_%0d", k), 64'(res_last), 64'(k == NW - 1));
      if (k == 5) res_in = ~res_pat;
      load_start = (k == 30);
      tick;
    end
    load_start = 1'b0;
    res_in = '0;
    chk("send_end_valid", 64'(res_valid), 64'd0);
    chk("send_end_last", 64'(res_last), 64'd0);
    chk("send_end_busy", 64'(busy), 64'd0);
    chk("send_ops_persist", 64'(ops_valid), 64'd1);
    chk_wide("send_m_kept", m_op, exp_m);

    // load_start and res_start together, res_start held through the load
    res_seen = 0;
    do_load(64'd3, -1, -1, 1'b0, 1'b1, rise);
    chk("coll_rise", 64'(rise), 64'd65);
    chk("coll_no_res", 64'(res_seen), 64'd0);
    build_exp(64'd3, 1'b0);
    chk_wide("coll_m", m_op, exp_m);

    // restart at beat 20
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_words(64'd100, k, 1'b0);
      tick;
    end
    in_valid = 1'b0;
    chk("restart_pre_ops", 64'(ops_valid), 64'd0);
    do_load(64'd200, -1, -1, 1'b0, 1'b0, rise);
    chk("restart_rise", 64'(rise), 64'd65);
    build_exp(64'd200, 1'b0);
    chk_ops("restart");

    // reset at load beat 30
    load_start = 1'b1;
    tick;
    load_start = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      set_words(64'd50, k, 1'b0);
      tick;
    end
    in_valid = 1'b0;
    reset = 1'b1;
    tick;
    chk("rl_busy", 64'(busy), 64'd0);
    chk("rl_ops_valid", 64'(ops_valid), 64'd0);
    chk("rl_res_valid", 64'(res_valid), 64'd0);
    chk("rl_err", 64'(err), 64'd0);
    chk_wide("rl_m_op", m_op, '0);
    chk_wide("rl_n_op", n_op, '0);
    reset = 1'b0;
    tick;

    // reset at send beat 30
    res_in = res_pat;
    res_start = 1'b1;
    tick;
    res_start = 1'b0;
    for (int k = 0; k < 30; k++) tick;
    chk("rs_mid_valid", 64'(res_valid), 64'd1);
    reset = 1'b1;
    tick;
    chk("rs_busy", 64'(busy), 64'd0);
    chk("rs_res_valid", 64'(res_valid), 64'd0);
    chk("rs_res_last", 64'(res_last), 64'd0);
    chk("rs_res_word", res_word, 64'd0);
    reset = 1'b0;
    res_in = '0;
    tick;
    do_load(64'd9, -1, -1, 1'b0, 1'b0, rise);
    chk("fresh_rise", 64'(rise), 64'd65);
    build_exp(64'd9, 1'b0);
    chk_ops("fresh");

    // even modulus, then odd reload
    do_load(64'd11, -1, -1, 1'b1, 1'b0, rise);
    build_exp(64'd11, 1'b1);
    chk_wide("even_n", n_op, exp_n);
`ifdef RSA_RX_ODD_CHECK_EN
    chk("even_rise", 64'(rise), 64'hFFFF_FFFF_FFFF_FFFF);
    chk("even_err", 64'(err), 64'd1);
    chk("even_ops_valid", 64'(ops_valid), 64'd0);
`else
    chk("even_rise", 64'(rise), 64'd65);
    chk("even_err", 64'(err), 64'd0);
    chk("even_ops_valid", 64'(ops_valid), 64'd1);
`endif
    do_load(64'd12, -1, -1, 1'b0, 1'b0, rise);
    chk("odd_rise", 64'(rise), 64'd65);
    chk("odd_err", 64'(err), 64'd0);
    chk("odd_ops_valid", 64'(ops_valid), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
